// File: rtl/execute_operand_stage.sv
// execute_operand_stage: ID/EX register, operand forwarding, immediate select, NZCV flags and ARM condition check
module execute_operand_stage #(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_stall_e,
    input  logic            i_flush_e,
    input  logic            i_arm_d,
    input  logic [4:0]      i_alu_control_d,
    input  logic            i_alu_src_d,
    input  logic [2:0]      i_shift_type_d,
    input  logic [4:0]      i_shift_amt_d,
    input  logic [XLEN-1:0] i_rd1_d,
    input  logic [XLEN-1:0] i_rd2_d,
    input  logic [XLEN-1:0] i_imm_ext_d,
    input  logic [RW-1:0]   i_rs1_d,
    input  logic [RW-1:0]   i_rs2_d,
    input  logic [RW-1:0]   i_rd_d,
    input  logic            i_reg_write_d,
    input  logic [1:0]      i_flag_write_d,
    input  logic [3:0]      i_cond_d,
    input  logic [1:0]      i_forward_a_e,
    input  logic [1:0]      i_forward_b_e,
    input  logic [XLEN-1:0] i_alu_result_m,
    input  logic [XLEN-1:0] i_result_w,
    input  logic [3:0]      i_alu_flags,
    output logic            o_arm_e,
    output logic [4:0]      o_alu_control_e,
    output logic [2:0]      o_shift_type_e,
    output logic [4:0]      o_shift_amt_e,
    output logic [XLEN-1:0] o_op1_e,
    output logic [XLEN-1:0] o_op2_e,
    output logic [XLEN-1:0] o_write_data_e,
    output logic [RW-1:0]   o_rs1_e,
    output logic [RW-1:0]   o_rs2_e,
    output logic [RW-1:0]   o_rd_e,
    output logic            o_reg_write_e,
    output logic [3:0]      o_flags_e,
    output logic            o_cond_ex_e
);
    logic            r_arm;
    logic [4:0]      r_alu_control;
    logic            r_alu_src;
    logic [2:0]      r_shift_type;
    logic [4:0]      r_shift_amt;
    logic [XLEN-1:0] r_rd1;
    logic [XLEN-1:0] r_rd2;
    logic [XLEN-1:0] r_imm;
    logic [RW-1:0]   r_rs1;
    logic [RW-1:0]   r_rs2;
    logic [RW-1:0]   r_rd;
    logic            r_reg_write;
    logic [1:0]      r_flag_write;
    logic [3:0]      r_cond;
    logic [3:0]      r_flags;
    logic            w_n, w_z, w_c, w_v;
    logic            w_cond_pass;
    logic            w_cond_ex;
    logic [XLEN-1:0] w_write_data;

    // E register: reset and flush both load a bubble; a stall holds the current instruction
    always_ff @(posedge clk) begin
        if (reset || i_flush_e) begin
            r_arm         <= 1'b0;
            r_alu_control <= '0;
            r_alu_src     <= 1'b0;
            r_shift_type  <= '0;
            r_shift_amt   <= '0;
            r_rd1         <= '0;
            r_rd2         <= '0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_reg_write   <= 1'b0;
            r_flag_write  <= '0;
            r_cond        <= '0;
        end else if (!i_stall_e) begin
            r_arm         <= i_arm_d;
            r_alu_control <= i_alu_control_d;
            r_alu_src     <= i_alu_src_d;
            r_shift_type  <= i_shift_type_d;
            r_shift_amt   <= i_shift_amt_d;
            r_rd1         <= i_rd1_d;
            r_rd2         <= i_rd2_d;
            r_imm         <= i_imm_ext_d;
            r_rs1         <= i_rs1_d;
            r_rs2         <= i_rs2_d;
            r_rd          <= i_rd_d;
            r_reg_write   <= i_reg_write_d;
            r_flag_write  <= i_flag_write_d;
            r_cond        <= i_cond_d;
        end
    end

    // NZCV commit happens only as the E instruction leaves (no stall); flush of the incoming one does not block it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else if (!i_stall_e && r_arm && w_cond_ex) begin
            if (r_flag_write[1]) r_flags[3:2] <= i_alu_flags[3:2];
            if (r_flag_write[0]) r_flags[1:0] <= i_alu_flags[1:0];
        end
    end

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // ARM condition decode against the architectural flags; AL and the 1111 encoding always pass
    always_comb begin
        w_cond_pass = 1'b1;
        case (r_cond)
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = !w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = !w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = !w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = !w_v;
            4'b1000: w_cond_pass = w_c && !w_z;
            4'b1001: w_cond_pass = !w_c || w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = !w_z && (w_n == w_v);
            4'b1101: w_cond_pass = w_z || (w_n != w_v);
            default: w_cond_pass = 1'b1;
        endcase
    end

    assign w_cond_ex = !r_arm || w_cond_pass;

    // Forwarding: 10 = memory-stage result, 01 = writeback result, 00/11 = register value
    assign o_op1_e = (i_forward_a_e == 2'b10) ? i_alu_result_m :
                     (i_forward_a_e == 2'b01) ? i_result_w : r_rd1;
    assign w_write_data = (i_forward_b_e == 2'b10) ? i_alu_result_m :
                          (i_forward_b_e == 2'b01) ? i_result_w : r_rd2;

    assign o_write_data_e  = w_write_data;
    assign o_op2_e         = r_alu_src ? r_imm : w_write_data;
    assign o_arm_e         = r_arm;
    assign o_alu_control_e = r_alu_control;
    assign o_shift_type_e  = r_shift_type;
    assign o_shift_amt_e   = r_shift_amt;
    assign o_rs1_e         = r_rs1;
    assign o_rs2_e         = r_rs2;
    assign o_rd_e          = r_rd;
    assign o_reg_write_e   = r_reg_write && w_cond_ex;
    assign o_flags_e       = r_flags;
    assign o_cond_ex_e     = w_cond_ex;
endmodule
